// File: rtl/testval_uart_reporter.sv
// testval_uart_reporter: sends test_val as "HHHH\r\n" over UART whenever it changes or on force_send.
module testval_uart_reporter #(
    parameter int CLKS_PER_BIT = 868,
    parameter int SKIP_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       test_val,
    input  logic              force_send,
    output logic              tx,
    output logic              busy,
    output logic              frame_done,
    output logic [SKIP_W-1:0] skipped
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_nx;
    logic [15:0] snapshot, last_sent, prev_val;
    logic        pending;
    logic [CW-1:0] baud_cnt;
    logic [2:0]  bit_idx, char_idx;
    logic [3:0]  nib;
    logic [7:0]  char_cur;
    logic        last_char, bit_end, start, changed;

    // tx lags the state by one register, so the final stop bit holds one extra
    // count to keep frame_done aligned with the end of the stop bit on the wire.
    always_comb begin
        last_char = char_idx == 3'd5;
        bit_end   = baud_cnt == CW'(state == STOP && last_char ? CLKS_PER_BIT : CLKS_PER_BIT - 1);
        start     = test_val != last_sent || pending || force_send;
        changed   = test_val != prev_val;
        nib       = 4'(snapshot >> (4'd12 - {char_idx[1:0], 2'b00}));
        char_cur  = char_idx == 3'd4 ? 8'h0D :
                    last_char        ? 8'h0A :
                    nib < 4'd10      ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
        state_nx  = state;
        unique case (state)
            IDLE:  state_nx = start ? START : IDLE;
            START: state_nx = bit_end ? DATA : START;
            DATA:  state_nx = bit_end && bit_idx == 3'd7 ? STOP : DATA;
            STOP:  state_nx = bit_end ? (last_char ? IDLE : START) : STOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            skipped    <= '0;
            snapshot   <= '0;
            last_sent  <= '0;
            prev_val   <= '0;
            pending    <= 1'b0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            char_idx   <= '0;
        end else begin
            state      <= state_nx;
            prev_val   <= test_val;
            tx         <= state == START ? 1'b0 : state == DATA ? char_cur[bit_idx] : 1'b1;
            frame_done <= state == STOP && state_nx == IDLE;
            baud_cnt   <= state == IDLE || bit_end ? '0 : baud_cnt + 1'b1;
            bit_idx    <= state == DATA && bit_end ? bit_idx + 3'd1 : bit_idx;
            char_idx   <= state == IDLE ? 3'd0 : state == STOP && bit_end ? char_idx + 3'd1 : char_idx;
            if (state == IDLE && start) begin
                snapshot  <= test_val;
                last_sent <= test_val;
                pending   <= 1'b0;
                busy      <= 1'b1;
            end else if (busy && (changed || force_send)) begin
                pending <= 1'b1;
            end
            if (busy && changed && skipped != '1)
                skipped <= skipped + 1'b1;
            if (state == STOP && state_nx == IDLE)
                busy <= 1'b0;
        end
    end
endmodule

// File: tb/tb_testval_uart_reporter.sv
// tb_testval_uart_reporter: directed checks of frame content, timing, change tracking and reset.
module tb_testval_uart_reporter;
    localparam int C = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] test_val = 16'h0000;
    logic        force_send = 1'b0;
    logic        tx, busy, frame_done;
    logic [7:0]  skipped;
    logic [15:0] tv2 = 16'h0000;
    logic        tx2, busy2, fd2;
    logic [1:0]  skipped2;

    int n_chk = 0, n_err = 0;
    int cyc = 0, fd_cnt = 0, tx_low = 0;
    int fall_cyc, fd_cyc, fd_prev, base_fd, base_low, s_cyc;
    logic [47:0] rx_word;

    testval_uart_reporter #(.CLKS_PER_BIT(C), .SKIP_W(8)) u_dut (
        .clk(clk), .rst(rst), .test_val(test_val), .force_send(force_send),
        .tx(tx), .busy(busy), .frame_done(frame_done), .skipped(skipped)
    );

    testval_uart_reporter #(.CLKS_PER_BIT(C), .SKIP_W(2)) u_sat (
        .clk(clk), .rst(rst), .test_val(tv2), .force_send(1'b0),
        .tx(tx2), .busy(busy2), .frame_done(fd2), .skipped(skipped2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (!tx) tx_low <= tx_low + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Samples each bit mid-cell; called from a negedge, returns one negedge after frame_done.
    task automatic rx_frame();
        int t = 0;
        logic bad = 1'b0;
        logic [7:0] b;
        do begin @(negedge clk); t++; end while (tx !== 1'b0 && t < 3000);
        if (tx !== 1'b0) begin
            chk("rx_start_timeout", 0, 1);
            return;
        end
        fall_cyc = cyc;
        rx_word = '0;
        repeat (C / 2) @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            if (tx !== 1'b0) bad = 1'b1;
            for (int i = 0; i < 8; i++) begin
                repeat (C) @(negedge clk);
                b[i] = tx;
            end
            repeat (C) @(negedge clk);
            if (tx !== 1'b1) bad = 1'b1;
            rx_word = {rx_word[39:0], b};
            if (c < 5) repeat (C) @(negedge clk);
        end
        chk("framing", bad, 0);
        t = 0;
        while (frame_done !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        fd_cyc = cyc;
        chk("frame_done_seen", frame_done, 1);
        chk("frame_len", fd_cyc - fall_cyc, 60 * C);
        chk("busy_fall", busy, 0);
        @(negedge clk);
        chk("frame_done_pulse", frame_done, 0);
    endtask

    task automatic pulse_force();
        force_send = 1'b1;
        @(negedge clk);
        force_send = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_skipped", skipped, 0);
        rst = 1'b0;

        base_fd = fd_cnt;
        base_low = tx_low;
        repeat (500) @(negedge clk);
        chk("idle_zero_tx", tx_low - base_low, 0);
        chk("idle_zero_fd", fd_cnt - base_fd, 0);
        chk("idle_zero_busy", busy, 0);

        test_val = 16'h1A3F;
        @(negedge clk);
        s_cyc = cyc;
        chk("start_busy", busy, 1);
        chk("start_tx_high", tx, 1);
        fork
            rx_frame();
            begin
                repeat (40) @(negedge clk); test_val = 16'h0002;
                repeat (20) @(negedge clk); test_val = 16'h0003;
                repeat (20) @(negedge clk); test_val = 16'hBEEF;
            end
        join
        chk("first_fall", fall_cyc - s_cyc, 1);
        chk("frame_1A3F", rx_word, 48'h31_41_33_46_0D_0A);
        chk("skipped_3", skipped, 3);
        fd_prev = fd_cyc;
        rx_frame();
        chk("b2b_gap", fall_cyc - fd_prev, 2);
        chk("frame_BEEF", rx_word, 48'h42_45_45_46_0D_0A);
        base_fd = fd_cnt;
        repeat (300) @(negedge clk);
        chk("no_stale_frames", fd_cnt - base_fd, 0);

        test_val = 16'h00FF;
        rx_frame();
        chk("frame_00FF", rx_word, 48'h30_30_46_46_0D_0A);
        repeat (20) @(negedge clk);
        pulse_force();
        fork
            rx_frame();
            begin repeat (50) @(negedge clk); pulse_force(); end
        join
        chk("force_idle", rx_word, 48'h30_30_46_46_0D_0A);
        fd_prev = fd_cyc;
        rx_frame();
        chk("force_busy", rx_word, 48'h30_30_46_46_0D_0A);
        chk("force_gap", fall_cyc - fd_prev, 2);
        base_fd = fd_cnt;
        repeat (300) @(negedge clk);
        chk("force_once", fd_cnt - base_fd, 0);

        test_val = 16'h1234;
        repeat (95) @(negedge clk);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_skipped", skipped, 0);
        rst = 1'b0;
        rx_frame();
        chk("frame_1234", rx_word, 48'h31_32_33_34_0D_0A);

        tv2 = 16'h0005;
        repeat (3) @(negedge clk);
        chk("sat_busy", busy2, 1);
        for (int k = 1; k <= 10; k++) begin
            tv2 = 16'(k * 16 + 7);
            repeat (3) @(negedge clk);
            if (k == 2) chk("sat_two", skipped2, 2);
        end
        chk("sat_max", skipped2, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
